// File: rtl/vmem_leak_engine.sv
// rtl/vmem_leak_engine.sv - membrane leak update VmemOut = Vmem + (Vrest-Vmem)*DeltaT/Taumem
// Optional feature macro VMEM_SATURATE_EN: V1 and the final add saturate instead of wrapping.
module vmem_leak_engine #(
  parameter int INTEGER_WIDTH   = 16,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH    = 4,
  parameter int NEURON_ID_WIDTH = 8
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [INTEGER_WIDTH-1:0]   Vrest,
  input  logic [DATA_WIDTH-1:0]      Vmem,
  input  logic [DELTAT_WIDTH-1:0]    DeltaT,
  input  logic [INTEGER_WIDTH-1:0]   Taumem,
  input  logic [NEURON_ID_WIDTH-1:0] NeuronIDIn,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [DATA_WIDTH-1:0]      VmemOut,
  output logic [NEURON_ID_WIDTH-1:0] NeuronIDOut,
  output logic                       ErrDivZero
);

  localparam int IW        = INTEGER_WIDTH;
  localparam int FW        = DATA_WIDTH_FRAC;
  localparam int DW        = DATA_WIDTH;
  localparam int DIV_WIDTH = DATA_WIDTH + DATA_WIDTH_FRAC;
  localparam int CNT_WIDTH = $clog2(DIV_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, ADD, DONE} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              vrest_q, vrest_d;
  logic [DW-1:0]              vmem_q, vmem_d;
  logic [DELTAT_WIDTH-1:0]    deltat_q, deltat_d;
  logic [IW-1:0]              taumem_q, taumem_d;
  logic [NEURON_ID_WIDTH-1:0] nid_q, nid_d;
  logic [DIV_WIDTH-1:0]       rem_q, rem_d;
  logic [DIV_WIDTH-1:0]       quo_q, quo_d;
  logic [DIV_WIDTH-1:0]       divisor_q, divisor_d;
  logic                       q_neg_q, q_neg_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [DW-1:0]              vmem_out_q, vmem_out_d;
  logic [NEURON_ID_WIDTH-1:0] nid_out_q, nid_out_d;
  logic                       err_q, err_d;

  logic [DW-1:0]                     v1;
  logic signed [DW+DELTAT_WIDTH-1:0] prod;
  logic [DW-1:0]                     mult_res;
  logic [DW-1:0]                     mult_mag;
  logic [IW-1:0]                     tau_mag;
  logic [DIV_WIDTH-1:0]              dividend;
  logic [DIV_WIDTH-1:0]              divisor;
  logic [DIV_WIDTH:0]                shifted;
  logic [DIV_WIDTH:0]                diff;
  logic                              ge;
  logic [DW-1:0]                     q_low;
  logic [DW-1:0]                     q_signed;
  logic [DW-1:0]                     sum;
  logic                              tau_zero;

`ifdef VMEM_SATURATE_EN
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] saturate(input logic [DW:0] x);
    if (x[DW] != x[DW-1]) return x[DW] ? SMIN : SMAX;
    return x[DW-1:0];
  endfunction

  logic [DW:0] v1_wide;
  logic [DW:0] sum_wide;
  assign v1_wide  = {vrest_q[IW-1], vrest_q, {FW{1'b0}}} - {vmem_q[DW-1], vmem_q};
  assign v1       = saturate(v1_wide);
  assign sum_wide = {vmem_q[DW-1], vmem_q} + {q_signed[DW-1], q_signed};
  assign sum      = saturate(sum_wide);
`else
  assign v1  = {vrest_q, {FW{1'b0}}} - vmem_q;
  assign sum = vmem_q + q_signed;
`endif

  // DeltaT sits at the top fraction bits, so V1*DeltaT>>>DELTAT_WIDTH equals the
  // truncated middle slice of the full fixed-point product.
  assign prod     = $signed(v1) * $signed({1'b0, deltat_q});
  assign mult_res = DW'(prod >>> DELTAT_WIDTH);
  assign mult_mag = mult_res[DW-1] ? -mult_res : mult_res;
  assign tau_mag  = taumem_q[IW-1] ? -taumem_q : taumem_q;
  assign tau_zero = (taumem_q == '0);
  assign dividend = {mult_mag, {FW{1'b0}}};
  assign divisor  = DIV_WIDTH'({tau_mag, {FW{1'b0}}});

  // Restoring step: the remainder never exceeds the divisor, so one extra bit suffices.
  assign shifted  = {rem_q, quo_q[DIV_WIDTH-1]};
  assign diff     = shifted - {1'b0, divisor_q};
  assign ge       = (shifted >= {1'b0, divisor_q});

  assign q_low    = quo_q[DW-1:0];
  assign q_signed = q_neg_q ? -q_low : q_low;

  always_comb begin
    state_d     = state_q;
    vrest_d     = vrest_q;
    vmem_d      = vmem_q;
    deltat_d    = deltat_q;
    taumem_d    = taumem_q;
    nid_d       = nid_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    divisor_d   = divisor_q;
    q_neg_d     = q_neg_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    vmem_out_d  = vmem_out_q;
    nid_out_d   = nid_out_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (InValid && in_ready_q) begin
          vrest_d    = Vrest;
          vmem_d     = Vmem;
          deltat_d   = DeltaT;
          taumem_d   = Taumem;
          nid_d      = NeuronIDIn;
          in_ready_d = 1'b0;
          state_d    = MULT;
        end
      end
      MULT: begin
        rem_d     = '0;
        cnt_d     = '0;
        divisor_d = divisor;
        if (tau_zero) begin
          quo_d   = '0;
          q_neg_d = 1'b0;
          state_d = ADD;
        end else begin
          quo_d   = dividend;
          q_neg_d = mult_res[DW-1] ^ taumem_q[IW-1];
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = ge ? DIV_WIDTH'(diff) : DIV_WIDTH'(shifted);
        quo_d = {quo_q[DIV_WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_WIDTH'(DIV_WIDTH - 1)) state_d = ADD;
      end
      ADD: begin
        vmem_out_d  = sum;
        nid_out_d   = nid_q;
        err_d       = tau_zero;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      vrest_q     <= '0;
      vmem_q      <= '0;
      deltat_q    <= '0;
      taumem_q    <= '0;
      nid_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      q_neg_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      vmem_out_q  <= '0;
      nid_out_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vrest_q     <= vrest_d;
      vmem_q      <= vmem_d;
      deltat_q    <= deltat_d;
      taumem_q    <= taumem_d;
      nid_q       <= nid_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      divisor_q   <= divisor_d;
      q_neg_q     <= q_neg_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      vmem_out_q  <= vmem_out_d;
      nid_out_q   <= nid_out_d;
      err_q       <= err_d;
    end
  end

  assign InReady     = in_ready_q;
  assign OutValid    = out_valid_q;
  assign VmemOut     = vmem_out_q;
  assign NeuronIDOut = nid_out_q;
  assign ErrDivZero  = err_q;

endmodule

// File: tb/tb_vmem_leak_engine.sv
// tb/tb_vmem_leak_engine.sv - directed vector bench for vmem_leak_engine
module tb_vmem_leak_engine;

  localparam int IW  = 16;
  localparam int DW  = 48;
  localparam int DTW = 4;
  localparam int NW  = 8;
  localparam longint ONE = longint'(1) << 32;
`ifdef VMEM_SATURATE_EN
  localparam longint SAT_EXP = -(longint'(1) << 43) - 1;
`else
  localparam longint SAT_EXP = 32767 * ONE + (ONE >>> 4);
`endif

  typedef struct {
    int     vrest;
    longint vmem;
    int     dt;
    int     tau;
    int     nid;
    longint exp_v;
    int     exp_err;
    int     exp_lat;
  } vec_t;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           InValid;
  logic           InReady;
  logic [IW-1:0]  Vrest;
  logic [DW-1:0]  Vmem;
  logic [DTW-1:0] DeltaT;
  logic [IW-1:0]  Taumem;
  logic [NW-1:0]  NeuronIDIn;
  logic           OutValid;
  logic           OutReady;
  logic [DW-1:0]  VmemOut;
  logic [NW-1:0]  NeuronIDOut;
  logic           ErrDivZero;

  int errors = 0;
  int checks = 0;
  vec_t vecs[8];

  vmem_leak_engine dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Vrest(Vrest), .Vmem(Vmem), .DeltaT(DeltaT), .Taumem(Taumem),
    .NeuronIDIn(NeuronIDIn), .OutValid(OutValid), .OutReady(OutReady),
    .VmemOut(VmemOut), .NeuronIDOut(NeuronIDOut), .ErrDivZero(ErrDivZero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint vout();
    return longint'($signed(VmemOut));
  endfunction

  task automatic start_job(input vec_t v);
    int w = 0;
    while (!InReady && w < 300) begin
      @(negedge Clock);
      w++;
    end
    Vrest      = v.vrest[IW-1:0];
    Vmem       = v.vmem[DW-1:0];
    DeltaT     = v.dt[DTW-1:0];
    Taumem     = v.tau[IW-1:0];
    NeuronIDIn = v.nid[NW-1:0];
    InValid    = 1'b1;
    @(negedge Clock);
    InValid    = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!OutValid && lat < 200) begin
      @(negedge Clock);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    check({tag, "_vmem"}, vout(), v.exp_v);
    check({tag, "_nid"}, longint'(NeuronIDOut), longint'(v.nid));
    check({tag, "_err"}, longint'(ErrDivZero), longint'(v.exp_err));
    check({tag, "_latency"}, longint'(lat), longint'(v.exp_lat));
    check({tag, "_inready_busy"}, longint'(InReady), 0);
  endtask

  task automatic consume(input string tag);
    OutReady = 1'b1;
    @(negedge Clock);
    OutReady = 1'b0;
    check({tag, "_outvalid_after"}, longint'(OutValid), 0);
    check({tag, "_inready_after"}, longint'(InReady), 1);
  endtask

  initial begin
    int lat;
    vecs[0] = '{-65,   -55 * ONE,             8, 10, 'h11, -55 * ONE - ONE / 2,   0, 82};
    vecs[1] = '{-70,   -70 * ONE,             15, 20, 'h3A, -70 * ONE,             0, 82};
    vecs[2] = '{0,     12 * ONE + ONE / 4,    5,  0, 'h05, 12 * ONE + ONE / 4,    1, 2};
    vecs[3] = '{32767, -32768 * ONE,          15, 1, 'h7F, SAT_EXP,               0, 82};
    vecs[4] = '{0,     ONE,                   1,  3, 'h42, ONE - 89478485,        0, 82};
    vecs[5] = '{10,    0,                     4, -4, 'hC3, -(ONE / 2 + ONE / 8),  0, 82};
    vecs[6] = '{0,     1,                     1,  1, 'h99, 0,                     0, 82};
    vecs[7] = '{100,   -3 * ONE,              15, 0, 'hFF, -3 * ONE,              1, 2};

    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    Vrest = '0; Vmem = '0; DeltaT = '0; Taumem = '0; NeuronIDIn = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check("rst_inready", longint'(InReady), 1);
    check("rst_outvalid", longint'(OutValid), 0);
    check("rst_vmemout", vout(), 0);
    check("rst_nid", longint'(NeuronIDOut), 0);
    check("rst_err", longint'(ErrDivZero), 0);

    for (int i = 0; i < 8; i++) begin
      start_job(vecs[i]);
      wait_out(lat);
      check_result($sformatf("v%0d", i), vecs[i], lat);
      consume($sformatf("v%0d", i));
    end

    // Back-pressure: results hold and new requests are ignored while OutReady is low.
    start_job(vecs[0]);
    wait_out(lat);
    Vrest = 16'd5; Vmem = '0; DeltaT = 4'd3; Taumem = 16'd2; NeuronIDIn = 8'hEE;
    InValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      check($sformatf("hold%0d_vmem", c), vout(), vecs[0].exp_v);
      check($sformatf("hold%0d_nid", c), longint'(NeuronIDOut), longint'(vecs[0].nid));
      check($sformatf("hold%0d_valid", c), longint'(OutValid), 1);
      check($sformatf("hold%0d_inready", c), longint'(InReady), 0);
    end
    InValid = 1'b0;
    consume("hold");
    repeat (5) @(negedge Clock);
    check("hold_no_ghost_job", longint'(OutValid), 0);

    // Reset 40 cycles into DIV, with InValid raised alongside it.
    start_job(vecs[1]);
    repeat (40) @(negedge Clock);
    Reset = 1'b1; InValid = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("midrst_outvalid", longint'(OutValid), 0);
    check("midrst_inready", longint'(InReady), 1);
    check("midrst_vmemout", vout(), 0);
    InValid = 1'b0;
    start_job(vecs[5]);
    wait_out(lat);
    check_result("postrst", vecs[5], lat);
    consume("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmem_leak_engine.md
VMEM_LEAK_ENGINE -- requirements
Module: vmem_leak_engine

Interface
REQ-001 SHALL have parameter INTEGER_WIDTH, default 16: integer bits of all fixed-point quantities.
REQ-002 SHALL have parameter DATA_WIDTH_FRAC, default 32: fractional bits.
REQ-003 SHALL have parameter DATA_WIDTH, default INTEGER_WIDTH+DATA_WIDTH_FRAC: membrane word width.
REQ-004 SHALL have parameter DELTAT_WIDTH, default 4: time-step field width.
REQ-005 SHALL have parameter NEURON_ID_WIDTH, default 8: width of the tag carried with each job.
REQ-006 SHALL have one clock and a synchronous, active-high reset, ports as follows:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  job request.
- InReady  out  1  engine can accept a job.
- Vrest  in  INTEGER_WIDTH  signed rest potential, integer only.
- Vmem  in  DATA_WIDTH  signed membrane potential.
- DeltaT  in  DELTAT_WIDTH  time step, unsigned, value DeltaT*2^-DELTAT_WIDTH.
- Taumem  in  INTEGER_WIDTH  signed membrane time constant, integer only.
- NeuronIDIn  in  NEURON_ID_WIDTH  job tag.
- OutValid  out  1  result available.
- OutReady  in  1  consumer accepts result.
- VmemOut  out  DATA_WIDTH  signed leaked potential.
- NeuronIDOut  out  NEURON_ID_WIDTH  tag of the result.
- ErrDivZero  out  1  result was produced with Taumem==0; qualified by OutValid.

Function
REQ-007 SHALL compute VmemOut = Vmem + ((Vrest-Vmem)*DeltaT)/Taumem in Q(INTEGER_WIDTH).(DATA_WIDTH_FRAC).
REQ-008 SHALL use FSM states IDLE, MULT, DIV, ADD, DONE.
REQ-009 SHALL drive InReady=1 only in IDLE.
REQ-010 SHALL, on InValid&InReady, register all inputs and NeuronIDIn, then go to MULT.
REQ-011 SHALL, in MULT (1 cycle), form V1=Vrest<<DATA_WIDTH_FRAC minus Vmem (DATA_WIDTH bits).
REQ-012 SHALL, in MULT, multiply V1 by DeltaT placed at fraction bits [DATA_WIDTH_FRAC-1 : DATA_WIDTH_FRAC-DELTAT_WIDTH].
REQ-013 SHALL keep product bits [DATA_WIDTH+DATA_WIDTH_FRAC-1 : DATA_WIDTH_FRAC] (truncating) as MultResult.
REQ-014 SHALL, in DIV, divide Dividend = MultResult<<DATA_WIDTH_FRAC (DATA_WIDTH+DATA_WIDTH_FRAC bits) by Taumem<<DATA_WIDTH_FRAC.
REQ-015 SHALL perform the division as an iterative restoring divider on magnitudes, one quotient bit per cycle, DATA_WIDTH+DATA_WIDTH_FRAC cycles, with the sign applied afterwards.
REQ-016 SHALL round the quotient toward zero and keep its lower DATA_WIDTH bits.
REQ-017 SHALL, when Taumem==0, skip DIV, force Quotient=0 (VmemOut=Vmem) and set ErrDivZero=1 for that result.
REQ-018 SHALL, in ADD (1 cycle), register VmemOut = Vmem + Quotient.
REQ-019 SHALL set OutValid=1 in DONE, DATA_WIDTH+DATA_WIDTH_FRAC+2 cycles after acceptance (82 with defaults); the Taumem==0 latency is 2 cycles.
REQ-020 SHALL hold VmemOut, NeuronIDOut and ErrDivZero stable while OutValid=1 and OutReady=0.
REQ-021 SHALL, on OutValid&OutReady, return to IDLE; InValid in that same cycle is not accepted (InReady=0 in DONE).
REQ-022 SHALL produce results in acceptance order, one job in flight.
REQ-023 SHALL give Vmem==Vrest<<DATA_WIDTH_FRAC exactly VmemOut=Vmem.

Reset
REQ-024 SHALL, on Reset=1 at a rising Clock edge, enter IDLE from any state and abandon any in-flight job.
REQ-025 SHALL reset outputs to InReady=1 (first cycle after reset), OutValid=0, VmemOut=0, NeuronIDOut=0, ErrDivZero=0.
REQ-026 SHALL give Reset priority over InValid and OutReady in the same cycle.

Configuration
REQ-027 SHALL support macro VMEM_SATURATE_EN.
- Defined: V1 and the final add saturate to signed DATA_WIDTH max/min.
- Undefined: both wrap in two's complement.

Verification
REQ-028 Vrest=-65, Vmem=-55.0, DeltaT=8, Taumem=10 -> after 82 cycles VmemOut=-55.5 and ErrDivZero=0.
REQ-029 Vmem=-70.0, Vrest=-70, DeltaT=15, Taumem=20, NeuronIDIn=0x3A -> VmemOut=-70.0, NeuronIDOut=0x3A.
REQ-030 Taumem=0, Vmem=12.25 -> OutValid after 2 cycles, VmemOut=12.25, ErrDivZero=1.
REQ-031 OutReady held 0 for 10 cycles after OutValid -> outputs stable, InReady=0, InValid ignored; OutReady=1 -> IDLE next cycle.
REQ-032 Reset pulse 40 cycles into DIV -> next cycle OutValid=0, InReady=1; a new job then completes with correct result.
REQ-033 Vrest=32767, Vmem=-32768.0, DeltaT=15, Taumem=1 -> macro defined: VmemOut within 2^-28 of -2048.0; undefined: VmemOut=32767.0625.
